pipe_stage_skid: RTL

- Parametrised, flushable pipeline stage register; generic successor to the fixed EX/MEM latch.
- Carries one packed payload per beat between stages using a valid/ready handshake.
- A 2-entry skid buffer keeps `in_ready` registered, so back-pressure does not form a combinational path across stages.
- Bubbles (`flush`, empty) present an all-zero payload, which is the NOP encoding, plus a saturating stall counter for performance debug.

---
 rtl/pipe_stage_skid_pkg.sv | 60 ++++++
 rtl/pipe_stage_skid_stall_counter.sv | 26 ++
 rtl/pipe_stage_skid.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the EX/MEM stage payload: width, field layout, NOP
// encoding and pack/unpack helpers used by producers and consumers of the beat.
package pipe_stage_skid_pkg;

  localparam int EXMEM_PAYLOAD_W = 197;

  // Field layout, MSB first: Instr, PC, PC4, PC8, ALUout, RT, RegAddr.
  localparam int REGADDR_LSB = 0;
  localparam int RT_LSB      = 5;
  localparam int ALUOUT_LSB  = 37;
  localparam int PC8_LSB     = 69;
  localparam int PC4_LSB     = 101;
  localparam int PC_LSB      = 133;
  localparam int INSTR_LSB   = 165;

  localparam logic [EXMEM_PAYLOAD_W-1:0] NOP_PAYLOAD = '0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic [31:0] alu_out;
    logic [31:0] rt;
    logic [4:0]  reg_addr;
  } exmem_t;

  // Source of the next value written into the main slot.
  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_IN   = 2'd1,
    LD_SKID = 2'd2
  } main_ld_e;

  function automatic logic [EXMEM_PAYLOAD_W-1:0] exmem_pack(input exmem_t f);
    logic [EXMEM_PAYLOAD_W-1:0] p;
    p = NOP_PAYLOAD;
    p[INSTR_LSB   +: 32] = f.instr;
    p[PC_LSB      +: 32] = f.pc;
    p[PC4_LSB     +: 32] = f.pc4;
    p[PC8_LSB     +: 32] = f.pc8;
    p[ALUOUT_LSB  +: 32] = f.alu_out;
    p[RT_LSB      +: 32] = f.rt;
    p[REGADDR_LSB +: 5]  = f.reg_addr;
    return p;
  endfunction

  function automatic exmem_t exmem_unpack(input logic [EXMEM_PAYLOAD_W-1:0] p);
    exmem_t f;
    f.instr    = p[INSTR_LSB   +: 32];
    f.pc       = p[PC_LSB      +: 32];
    f.pc4      = p[PC4_LSB     +: 32];
    f.pc8      = p[PC8_LSB     +: 32];
    f.alu_out  = p[ALUOUT_LSB  +: 32];
    f.rt       = p[RT_LSB      +: 32];
    f.reg_addr = p[REGADDR_LSB +: 5];
    return f;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_stall_counter.sv
// Saturating event counter for stall-cycle performance debug; cleared only by reset.
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Stick at all-ones rather than wrapping so long stalls stay visible.
    if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Flushable valid/ready pipeline register with a 2-entry skid buffer so that
// in_ready comes straight from a flop; bubbles present the all-zero NOP payload.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int PAYLOAD_W = EXMEM_PAYLOAD_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic                 main_v_q, main_v_d;
  logic                 skid_v_q, skid_v_d;
  logic [PAYLOAD_W-1:0] main_data_q, main_data_d;
  logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;

  logic     acc, pop, skid_ld, stall;
  main_ld_e main_ld;

  assign in_ready    = ~skid_v_q & ~reset;
  assign acc         = in_valid & in_ready;
  assign pop         = main_v_q & out_ready;
  assign out_valid   = main_v_q;
  assign out_payload = main_v_q ? main_data_q : '0;
  assign occupancy   = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    main_ld     = LD_NONE;
    skid_ld     = 1'b0;

    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_data_d = '0;
      skid_data_d = '0;
    end else begin
      if (!main_v_q) begin
        if (acc) begin
          main_ld  = LD_IN;
          main_v_d = 1'b1;
        end
      end else if (pop) begin
        // skid full implies in_ready=0, so no new beat competes with it here.
        if (skid_v_q) begin
          main_ld  = LD_SKID;
          skid_v_d = 1'b0;
        end else if (acc) begin
          main_ld  = LD_IN;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (acc) begin
        skid_ld  = 1'b1;
        skid_v_d = 1'b1;
      end

      // Data flops only move when a slot is loaded; stale data behind a
      // cleared valid bit is masked at the output.
      case (main_ld)
        LD_IN:   main_data_d = in_payload;
        LD_SKID: main_data_d = skid_data_q;
        default: main_data_d = main_data_q;
      endcase
      if (skid_ld) skid_data_d = in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  // A flushing cycle is not counted as a stall.
  assign stall = main_v_q & ~out_ready & ~flush;

  pipe_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .cnt   (stall_cnt)
  );

endmodule
